// File: rtl/sec32_pkg.sv
// Shared constants and types for the 32-bit SEC encoder slice.
// Holds the check-bit masks, the {check,data} codeword layout and the parity helper.
package sec32_pkg;

    localparam int DATA_W = 32;
    localparam int CHK_W  = 8;
    localparam int CW_W   = DATA_W + CHK_W;
    localparam int INJ_W  = 6;

    // Element k selects the data bits that feed check bit k (Gic k).
    localparam logic [CHK_W-1:0][DATA_W-1:0] MASK = {
        32'h8888F0F0,
        32'h44440F0F,
        32'h2222FF00,
        32'h111100FF,
        32'hF0F08888,
        32'h0F0F4444,
        32'hFF002222,
        32'h00FF1111
    };

    // Data occupies codeword bits 0..31, check bits occupy 32..39.
    typedef struct packed {
        logic [CHK_W-1:0]  check;
        logic [DATA_W-1:0] data;
    } codeword_t;

    // Each check bit is the even parity of the data bits its mask selects.
    function automatic logic [CHK_W-1:0] calc_check(input logic [DATA_W-1:0] data);
        logic [CHK_W-1:0] chk;
        chk = '0;
        for (int k = 0; k < CHK_W; k++) begin
            chk[k] = ^(data & MASK[k]);
        end
        return chk;
    endfunction

endpackage

// File: rtl/sec32_check_gen.sv
// Pure combinational 32-bit data to 8-bit SEC check-bit generator.
// Stateless, so the same block can sit anywhere a check word is needed.
module sec32_check_gen
    import sec32_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    output logic [CHK_W-1:0]  check
);

    // Fold every masked subset of the data word down to one parity bit.
    always_comb begin
        check = calc_check(data);
    end

endmodule

// File: rtl/sec32_encoder.sv
// Two-stage elastic SEC encoder: stage 1 captures the data word, stage 2 holds
// data plus generated check bits for the downstream corrector.
// Optional build macro SEC32_ERR_INJECT_EN adds inj_en/inj_bit ports that flip one
// bit of the outgoing {check,data} codeword for fault-injection testing.
module sec32_encoder
    import sec32_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
`ifdef SEC32_ERR_INJECT_EN
    input  logic              inj_en,
    input  logic [INJ_W-1:0]  inj_bit,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CHK_W-1:0]  out_check,
    output logic              out_r,
    output logic [CNT_W-1:0]  word_cnt
);

    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic [CHK_W-1:0]  s1_check;
    logic              s2_valid;
    codeword_t         s2_word;
    logic [CW_W-1:0]   s2_next;
    logic              s1_load;
    logic              s2_load;
`ifdef SEC32_ERR_INJECT_EN
    logic              s1_inj_en;
    logic [INJ_W-1:0]  s1_inj_bit;
    logic [CW_W-1:0]   inj_flip;
`endif

    // Each stage advances when it is empty or the stage after it is taking its word,
    // so a full pipeline still moves every cycle while the sink accepts.
    assign s2_load  = !s2_valid || out_ready;
    assign s1_load  = !s1_valid || s2_load;
    assign in_ready = s1_load;

    sec32_check_gen u_check_gen (
        .data  (s1_data),
        .check (s1_check)
    );

`ifdef SEC32_ERR_INJECT_EN
    // Build the codeword for stage 2 and invert the selected bit; selections past
    // bit 39 shift out of the 40-bit mask and leave the word untouched.
    always_comb begin
        inj_flip = '0;
        if (s1_inj_en && (s1_inj_bit < INJ_W'(CW_W))) begin
            inj_flip = CW_W'(1) << s1_inj_bit;
        end
        s2_next = {s1_check, s1_data} ^ inj_flip;
    end
`else
    // Build the codeword for stage 2 from the captured data and its check bits.
    always_comb begin
        s2_next = {s1_check, s1_data};
    end
`endif

    // Stage 1: capture the input word only on a handshake so idle-bus garbage never enters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
`ifdef SEC32_ERR_INJECT_EN
            s1_inj_en  <= 1'b0;
            s1_inj_bit <= '0;
`endif
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data    <= in_data;
`ifdef SEC32_ERR_INJECT_EN
                s1_inj_en  <= inj_en;
                s1_inj_bit <= inj_bit;
`endif
            end
        end
    end

    // Stage 2: hold the finished codeword until the sink takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_word  <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_word <= codeword_t'(s2_next);
            end
        end
    end

    // Count completed output handshakes, wrapping naturally at the counter width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt <= '0;
        end else if (s2_valid && out_ready) begin
            word_cnt <= word_cnt + CNT_W'(1);
        end
    end

    assign out_valid = s2_valid;
    assign out_r     = s2_valid;
    assign out_data  = s2_word.data;
    assign out_check = s2_word.check;

endmodule

// File: tb/tb_sec32_encoder.sv
// Scoreboard bench for sec32_encoder: a 16-bit-counter instance and a 4-bit-counter
// instance share one stimulus stream; expected words are queued at input handshake
// and a negedge monitor checks outputs, counters and latency against them.
module tb_sec32_encoder;

    typedef struct {
        logic [31:0] data;
        logic [7:0]  check;
        int          acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        in_ready, out_valid, out_r;
    logic [31:0] out_data;
    logic [7:0]  out_check;
    logic [15:0] word_cnt;
    logic        in_ready4, out_valid4, out_r4;
    logic [31:0] out_data4;
    logic [7:0]  out_check4;
    logic [3:0]  word_cnt4;
`ifdef SEC32_ERR_INJECT_EN
    logic        inj_en = 1'b0;
    logic [5:0]  inj_bit = '0;
`endif

    exp_t exp_q[$];
    int   cyc = 0;
    int   done_cnt = 0;
    int   n_checks = 0;
    int   n_pass = 0;

    sec32_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
`ifdef SEC32_ERR_INJECT_EN
        .inj_en(inj_en), .inj_bit(inj_bit),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_check(out_check), .out_r(out_r), .word_cnt(word_cnt)
    );

    sec32_encoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready4), .in_data(in_data),
`ifdef SEC32_ERR_INJECT_EN
        .inj_en(inj_en), .inj_bit(inj_bit),
`endif
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_check(out_check4), .out_r(out_r4), .word_cnt(word_cnt4)
    );

    // Free-running clock and cycle index used to time-stamp accepted words.
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: check bit k is odd/even population of the masked data bits.
    function automatic logic [7:0] ref_check(input logic [31:0] d);
        logic [31:0] m [8];
        logic [7:0]  c;
        m = '{32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
              32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0};
        c = '0;
        for (int k = 0; k < 8; k++) begin
            c[k] = ($countones(d & m[k]) % 2) == 1;
        end
        return c;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // One cycle of stimulus; expchk < 0 means take the check bits from the reference.
    task automatic applyStimulus(input bit v, input logic [31:0] d, input bit rdy, input int expchk);
        exp_t e;
        logic [5:0] sel;
        @(posedge clk);
        #1;
        in_valid  = v;
        in_data   = v ? d : 32'hxxxxxxxx;
        out_ready = rdy;
        #1;
        checkOutput("in_ready", in_ready, (exp_q.size() < 2) || rdy);
        checkOutput("dut4_in_ready", in_ready4, (exp_q.size() < 2) || rdy);
        @(negedge clk);
        if (in_valid && in_ready) begin
            e.data  = d;
            e.check = (expchk < 0) ? ref_check(d) : expchk[7:0];
            e.acc   = cyc;
            sel     = '0;
`ifdef SEC32_ERR_INJECT_EN
            sel = inj_bit;
            if (inj_en && sel < 6'd32) begin
                e.data = e.data ^ (32'd1 << sel);
            end else if (inj_en && sel < 6'd40) begin
                sel = sel - 6'd32;
                e.check = e.check ^ (8'd1 << sel);
            end
`endif
            if (sel == 6'd63) e.acc = cyc;
            exp_q.push_back(e);
        end
    endtask

    // Assert reset asynchronously between edges and check the cleared state.
    task automatic applyReset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        exp_q.delete();
        done_cnt = 0;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_r", out_r, 0);
        checkOutput("rst_out_data", out_data, 0);
        checkOutput("rst_out_check", out_check, 0);
        checkOutput("rst_word_cnt", word_cnt, 0);
        checkOutput("rst_dut4_out_valid", out_valid4, 0);
        checkOutput("rst_word_cnt4", word_cnt4, 0);
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    task automatic drain();
        int budget;
        budget = 20;
        while (exp_q.size() > 0 && budget > 0) begin
            applyStimulus(1'b0, 32'h0, 1'b1, -1);
            budget--;
        end
        checkOutput("drain_timeout_left", exp_q.size(), 0);
    endtask

    // Monitor: output presence, ordering, data/check, counters, checked every cycle.
    always @(negedge clk) begin
        exp_t e;
        bit   present;
        if (rst_n) begin
            present = (exp_q.size() > 0) && (cyc >= exp_q[0].acc + 2);
            checkOutput("out_valid", out_valid, present);
            checkOutput("out_r", out_r, present);
            checkOutput("dut4_out_valid", out_valid4, present);
            checkOutput("dut4_out_r", out_r4, present);
            checkOutput("word_cnt", word_cnt, done_cnt[15:0]);
            checkOutput("word_cnt4", word_cnt4, done_cnt[3:0]);
            if (out_valid && exp_q.size() > 0) begin
                e = exp_q[0];
                checkOutput("out_data", out_data, e.data);
                checkOutput("out_check", out_check, e.check);
                checkOutput("dut4_out_data", out_data4, e.data);
                checkOutput("dut4_out_check", out_check4, e.check);
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    done_cnt++;
                end
            end
        end
    end

    initial begin
        applyReset();

        // Directed known-answer vectors with continuous out_ready.
        applyStimulus(1'b1, 32'h00000000, 1'b1, 8'h00);
        applyStimulus(1'b1, 32'h00000001, 1'b1, 8'h51);
        applyStimulus(1'b1, 32'h80000000, 1'b1, 8'h8A);
        applyStimulus(1'b1, 32'hFFFFFFFF, 1'b1, 8'h00);
        drain();
        checkOutput("basic_word_cnt", word_cnt, 4);

        // 100 back-to-back random words.
        applyReset();
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, $urandom, 1'b1, -1);
        drain();
        checkOutput("stream_word_cnt", word_cnt, 100);
        checkOutput("stream_word_cnt4", word_cnt4, 4);

        // Backpressure window of five cycles in the middle of a stream.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom, 1'b1, -1);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, $urandom, 1'b0, -1);
        checkOutput("bp_full_in_ready", in_ready, 0);
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, $urandom, 1'b1, -1);
        drain();

        // Random valid/ready mix.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0), -1);
        end
        drain();

        // Reset with both stages holding words, then one clean word.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, $urandom, 1'b0, -1);
        checkOutput("pre_reset_out_valid", out_valid, 1);
        applyReset();
        applyStimulus(1'b1, 32'h00000001, 1'b1, 8'h51);
        drain();

        // 17 handshakes wrap the 4-bit counter to 1.
        applyReset();
        for (int i = 0; i < 17; i++) applyStimulus(1'b1, $urandom, 1'b1, -1);
        drain();
        checkOutput("wrap_word_cnt4", word_cnt4, 1);
        checkOutput("wrap_word_cnt", word_cnt, 17);

`ifdef SEC32_ERR_INJECT_EN
        applyReset();
        inj_en = 1'b1;
        inj_bit = 6'd35;
        applyStimulus(1'b1, 32'h0, 1'b1, -1);
        inj_bit = 6'd31;
        applyStimulus(1'b1, 32'h0, 1'b1, -1);
        inj_bit = 6'd45;
        applyStimulus(1'b1, 32'h0, 1'b1, -1);
        inj_en = 1'b0;
        drain();
        checkOutput("inj_word_cnt", word_cnt, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
